// File: rtl/mem_pkg.sv
// ============================================================================
// mem_pkg : shared sequencer state type and memory geometry defaults
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_pkg;

  localparam int MEM_WIDTH = 16;
  localparam int MEM_SIZE  = 64;

  typedef enum logic [1:0] {IDLE, LOAD, PRIME, STREAM} mem_seq_state_t;

endpackage

`default_nettype wire

// File: rtl/memory.sv
// ============================================================================
// memory : single-port RAM, write on wr_en, one-cycle registered read
// Revision: 1.0
// ============================================================================
`default_nettype none

module memory
  import mem_pkg::*;
#(
  parameter  int WIDTH   = MEM_WIDTH,
  parameter  int SIZE    = MEM_SIZE,
  localparam int LOGSIZE = $clog2(SIZE)
) (
  input  logic               clk,
  input  logic [LOGSIZE-1:0] addr,
  input  logic [WIDTH-1:0]   data_in,
  input  logic               wr_en,
  output logic [WIDTH-1:0]   data_out
);

  logic [WIDTH-1:0] mem [SIZE];

  always_ff @(posedge clk) begin
    if (wr_en) mem[addr] <= data_in;
    data_out <= mem[addr];
  end

endmodule

`default_nettype wire

// File: rtl/mem_load_stream.sv
// ============================================================================
// mem_load_stream : loads a burst into memory, then streams it back out
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_load_stream
  import mem_pkg::*;
#(
  parameter  int WIDTH   = MEM_WIDTH,
  parameter  int SIZE    = MEM_SIZE,
  localparam int LOGSIZE = $clog2(SIZE)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [LOGSIZE:0]   len,
  output logic               busy,
  output logic               done,
  input  logic [WIDTH-1:0]   s_data,
  input  logic               s_valid,
  output logic               s_ready,
  output logic [WIDTH-1:0]   m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               m_last,
  output logic [LOGSIZE-1:0] mem_addr,
  output logic [WIDTH-1:0]   mem_data_in,
  output logic               mem_wr_en,
  input  logic [WIDTH-1:0]   mem_data_out
);

  mem_seq_state_t     state, state_nxt;
  logic [LOGSIZE-1:0] wr_ptr, rd_ptr;
  logic [LOGSIZE:0]   len_q;
  logic [LOGSIZE:0]   last_idx;
  logic               done_q;
  logic               len_ok;
  logic               wr_last, rd_last;

  assign len_ok   = (len != '0) && (len <= (LOGSIZE+1)'(SIZE));
  assign last_idx = len_q - (LOGSIZE+1)'(1);
  assign wr_last  = ({1'b0, wr_ptr} == last_idx);
  assign rd_last  = ({1'b0, rd_ptr} == last_idx);

  assign m_data      = mem_data_out;
  assign mem_data_in = s_data;
  assign done        = done_q;

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    s_ready   = 1'b0;
    m_valid   = 1'b0;
    m_last    = 1'b0;
    mem_wr_en = 1'b0;
    mem_addr  = '0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start && len_ok) state_nxt = LOAD;
      end
      LOAD: begin
        s_ready   = 1'b1;
        mem_wr_en = s_valid;
        mem_addr  = wr_ptr;
        if (s_valid && wr_last) state_nxt = PRIME;
      end
      PRIME: state_nxt = STREAM;
      STREAM: begin
        m_valid = 1'b1;
        m_last  = rd_last;
        // Look one address ahead on a handshake so the next word arrives without a bubble.
        mem_addr = m_ready ? rd_ptr + LOGSIZE'(1) : rd_ptr;
        if (m_ready && rd_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      len_q  <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= (state == STREAM) && m_ready && rd_last;
      case (state)
        IDLE: begin
          if (start && len_ok) begin
            len_q  <= len;
            wr_ptr <= '0;
            rd_ptr <= '0;
          end
        end
        LOAD:   if (s_valid) wr_ptr <= wr_ptr + LOGSIZE'(1);
        STREAM: if (m_ready && !rd_last) rd_ptr <= rd_ptr + LOGSIZE'(1);
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_load_stream.sv
// ============================================================================
// tb_mem_load_stream : scoreboard bench for mem_load_stream + memory
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_load_stream;
  import mem_pkg::*;

  localparam int WIDTH   = 16;
  localparam int SIZE    = 64;
  localparam int LOGSIZE = $clog2(SIZE);

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               start = 1'b0;
  logic [LOGSIZE:0]   len = '0;
  logic               busy, done, s_ready, m_valid, m_last, mem_wr_en;
  logic [WIDTH-1:0]   s_data = '0;
  logic               s_valid = 1'b0;
  logic               m_ready = 1'b1;
  logic [WIDTH-1:0]   m_data, mem_data_in, mem_data_out;
  logic [LOGSIZE-1:0] mem_addr;

  always #5 clk = ~clk;

  mem_load_stream #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .len(len), .busy(busy), .done(done),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_wr_en(mem_wr_en),
    .mem_data_out(mem_data_out)
  );

  memory #(.WIDTH(WIDTH), .SIZE(SIZE)) mem_i (
    .clk(clk), .addr(mem_addr), .data_in(mem_data_in), .wr_en(mem_wr_en), .data_out(mem_data_out)
  );

  typedef struct packed { logic [WIDTH-1:0] data; logic last; } out_t;
  typedef struct packed { logic [LOGSIZE-1:0] addr; logic [WIDTH-1:0] data; } wr_t;

  out_t             exp_q[$];
  wr_t              wr_q[$];
  logic [WIDTH-1:0] stim_q[$];
  int               tests = 0;
  int               fails = 0;
  int               ready_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Downstream ready: 0 = always ready, 1 = pattern 1,0,0,..., 2 = random
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       m_ready = 1'b1;
        1:       begin m_ready = (ph % 3 == 0); ph++; end
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops expected writes and output words as the DUT presents them
  logic             done_exp = 1'b0;
  logic             in_stream = 1'b0;
  logic             prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_data = '0;

  always @(negedge clk) begin
    if (!reset_n) begin
      done_exp   = 1'b0;
      in_stream  = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (done_exp || done) check("done_pulse", 32'(done), 32'(done_exp));
      done_exp = 1'b0;
      if (mem_wr_en) begin
        check("wr_en_needs_valid", 32'(s_valid), 32'd1);
        if (wr_q.size() == 0) check("unexpected_write", 32'd1, 32'd0);
        else begin
          wr_t w;
          w = wr_q.pop_front();
          check("write_addr", 32'(mem_addr), 32'(w.addr));
          check("write_data", 32'(mem_data_in), 32'(w.data));
        end
      end
      if (in_stream && !m_valid) check("m_valid_dropped", 32'(m_valid), 32'd1);
      if (prev_stall && m_valid) check("stall_data_stable", 32'(m_data), 32'(prev_data));
      if (m_valid) in_stream = 1'b1;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) check("unexpected_output", 32'd1, 32'd0);
        else begin
          out_t e;
          e = exp_q.pop_front();
          check("m_data", 32'(m_data), 32'(e.data));
          check("m_last", 32'(m_last), 32'(e.last));
        end
        if (m_last) begin
          done_exp  = 1'b1;
          in_stream = 1'b0;
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  task automatic check_all_zero(input string name);
    check(name, {25'd0, busy, done, s_ready, m_valid, m_last, mem_wr_en, |mem_addr}, 32'd0);
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) stim_q.push_back(WIDTH'($urandom));
  endtask

  // gap >= 0: fixed idle cycles before each word; gap < 0: random 0..3
  task automatic run_burst(input int n, input int gap, input bit overlap, input int abort_after);
    bit seen;
    @(posedge clk); #1;
    start = 1'b1; len = (LOGSIZE+1)'(n);
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    check("s_ready_in_load", 32'(s_ready), 32'd1);
    for (int i = 0; i < n; i++) begin
      logic [WIDTH-1:0] w;
      if (abort_after > 0 && i == abort_after) begin
        reset_n = 1'b0;
        #1;
        check_all_zero("outputs_during_reset");
        exp_q.delete();
        wr_q.delete();
        stim_q.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
        return;
      end
      repeat (gap >= 0 ? gap : $urandom_range(0, 3)) begin @(posedge clk); #1; end
      w = stim_q.pop_front();
      s_data = w; s_valid = 1'b1;
      exp_q.push_back({w, (i == n - 1)});
      wr_q.push_back({LOGSIZE'(i), w});
      @(posedge clk); #1;
      s_valid = 1'b0;
      s_data = WIDTH'($urandom);
    end
    @(negedge clk);
    check("prime_no_valid", {30'd0, m_valid, s_ready}, 32'd0);
    @(negedge clk);
    check("stream_valid", 32'(m_valid), 32'd1);
    if (overlap) begin
      @(posedge clk); #1;
      start = 1'b1; len = (LOGSIZE+1)'(3);
      @(posedge clk); #1;
      start = 1'b0;
    end
    seen = 1'b0;
    for (int c = 0; c < 2000 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("done_seen", 32'(seen), 32'd1);
    check("idle_after_done", 32'(busy), 32'd0);
  endtask

  task automatic try_illegal(input int n);
    @(posedge clk); #1;
    start = 1'b1; len = (LOGSIZE+1)'(n);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("illegal_len_ignored", 32'(busy), 32'd0);
  endtask

  initial begin
    #2;
    check_all_zero("reset_values");
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check_all_zero("idle_values");

    try_illegal(0);
    try_illegal(SIZE + 1);

    ready_mode = 0;
    stim_q.push_back(16'h0011); stim_q.push_back(16'h0022);
    stim_q.push_back(16'h0033); stim_q.push_back(16'h0044);
    run_burst(4, 0, 1'b0, 0);

    fill_random(3);  run_burst(3, 2, 1'b0, 0);
    ready_mode = 1;
    fill_random(5);  run_burst(5, 0, 1'b0, 0);
    ready_mode = 0;
    fill_random(SIZE); run_burst(SIZE, 0, 1'b0, 0);
    ready_mode = 2;
    fill_random(6);  run_burst(6, -1, 1'b1, 0);

    ready_mode = 0;
    fill_random(6);  run_burst(6, 0, 1'b0, 2);
    fill_random(2);  run_burst(2, 0, 1'b0, 0);

    for (int k = 0; k < 6; k++) begin
      int n;
      n = $urandom_range(1, SIZE);
      ready_mode = $urandom_range(0, 2);
      fill_random(n);
      run_burst(n, -1, 1'($urandom_range(0, 1)), 0);
    end

    repeat (3) @(negedge clk);
    check("exp_queue_drained", 32'(exp_q.size()), 32'd0);
    check("wr_queue_drained", 32'(wr_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_load_stream.md
# mem_load_stream

Sequencer sitting directly in front of the single-port `memory` block (WIDTH-bit words, SIZE entries, one-cycle registered read, write on `wr_en`).
- Accepts a burst of `len` words on a valid/ready input stream and writes them to consecutive addresses from 0.
- Then reads them back in order and presents them on a valid/ready output stream with full throughput and backpressure.
- Used to stage operand vectors before the compute datapath consumes them.

## Interface
- `WIDTH`, 16, bits per word; must match the memory instance.
- `SIZE`, 64, words in memory; maximum burst length.
- `LOGSIZE`, localparam `$clog2(SIZE)`, memory address width.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a burst; sampled only in IDLE.
- `len`  in  LOGSIZE+1  burst length; sampled with `start`; legal range 1..SIZE.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the last output handshake.
- `s_data`  in  WIDTH  input word.
- `s_valid`  in  1  input word valid.
- `s_ready`  out  1  block accepts an input word.
- `m_data`  out  WIDTH  output word; wired directly from `mem_data_out`.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  downstream accepts the output word.
- `m_last`  out  1  marks the final word of the burst; qualified by `m_valid`.
- `mem_addr`  out  LOGSIZE  memory address.
- `mem_data_in`  out  WIDTH  memory write data; equals `s_data`.
- `mem_wr_en`  out  1  memory write enable.
- `mem_data_out`  in  WIDTH  memory read data; valid one cycle after the address is presented.

## Operation
- **IDLE**: `s_ready`=0, `m_valid`=0.
  - `start` with `len` in 1..SIZE: latch `len`, clear `wr_ptr` and `rd_ptr`, go to LOAD.
  - `len`=0 or `len`>SIZE: ignore `start`, stay in IDLE.
- **LOAD**: `s_ready`=1.
  - `mem_wr_en` = `s_valid`; `mem_addr` = `wr_ptr`.
  - On each handshake, increment `wr_ptr`.
  - On the handshake where `wr_ptr`==`len`-1, go to PRIME.
- **PRIME**: exactly one cycle, `s_ready`=0, `mem_addr`=0, `mem_wr_en`=0. Go to STREAM.
- **STREAM**: `m_valid`=1; `m_last` = (`rd_ptr`==`len`-1).
  - `mem_addr` is combinational: `rd_ptr`+1 when `m_valid`&`m_ready`, otherwise `rd_ptr`.
  - When stalled, the address is held, so `mem_data_out` (and therefore `m_data`) stays stable.
  - Handshake without `m_last`: increment `rd_ptr`.
  - Handshake with `m_last`: go to IDLE and pulse `done` in the next cycle.
- `mem_wr_en` is 0 outside LOAD. `mem_addr` is 0 in IDLE.
- `start` while busy is ignored. `s_valid` outside LOAD is ignored.
- Pointers are LOGSIZE bits wide. When `len`=SIZE, the write pointer wraps to 0 only as the state leaves LOAD, which is harmless.
- Reset is asynchronous and may occur mid-burst:
  - State returns to IDLE; pointers, `done`, `busy`, `s_ready`, `m_valid`, `m_last`, `mem_wr_en` and `mem_addr` go to 0.
  - Memory contents are untouched.

## Timing
- Reset values: every output is 0. `m_data` and `mem_data_in` follow their inputs.
- `start` sampled at edge t: `busy`=1 and `s_ready`=1 from cycle t+1.
- Each accepted input word is written at the same edge it is accepted; no buffering.
- After the last write edge: PRIME for one cycle, then `m_valid`=1 with word 0 on `m_data`.
- Output throughput is one word per cycle while `m_ready`=1; there are no bubbles between words.
- Minimum burst duration: `len` (load) + 1 (prime) + `len` (stream) cycles. `done` rises the cycle after the final handshake.
- `m_valid` never drops while asserted until the final handshake; `m_data` is stable during a stall.

## Structure
- Shared package `mem_pkg`:
  - `typedef enum logic [1:0] {IDLE, LOAD, PRIME, STREAM} mem_seq_state_t`.
  - Default `WIDTH`/`SIZE` constants shared with `memory`.
- Single flat module: one state register, `wr_ptr`, `rd_ptr`, latched `len`, `done` flop.
- No sub-module. The bench instantiates `mem_load_stream` together with `memory`.

## Test plan
- **Basic burst**: `len`=4, inputs 0x0011, 0x0022, 0x0033, 0x0044, `m_ready`=1 → outputs in the same order on 4 consecutive cycles starting 2 cycles after the last write. `m_last` is high only on 0x0044, then `done`=1 for one cycle.
- **Input gaps**: `len`=3 with `s_valid` gaps of 2 cycles → exactly 3 writes, to addresses 0, 1, 2. `mem_wr_en` is never high without `s_valid`.
- **Backpressure**: `len`=5, `m_ready` toggling 1,0,0,1,… → no word dropped or duplicated. `m_data` is constant across every stalled cycle.
- **Full depth**: `len`=64 with random data → all 64 words returned in order; `m_last` on word 63; back to IDLE.
- **Illegal and overlapping requests**: `start` with `len`=0 → `busy` stays 0. `start` pulsed during STREAM → ignored, the burst completes unchanged.
- **Reset mid-operation**: assert `reset_n`=0 during LOAD after 2 of 6 words → all outputs 0 immediately. After release, a fresh `len`=2 burst works correctly.
